// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

    // Controller states: normal issue, waiting on data memory, frozen after timeout
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    // Bit positions of the inter-stage buffers inside the internal enable/flush vectors
    localparam int BUF1     = 0;   // IF/ID
    localparam int BUF2     = 1;   // ID/EX
    localparam int BUF3     = 2;   // EX/MEM
    localparam int BUF4     = 3;   // MEM/WB
    localparam int NUM_BUFS = 4;

    // Parameter defaults for the top level
    localparam int MEM_TIMEOUT_DEF = 16;
    localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources of the ID instruction.
// Latency: purely combinational, same cycle.
// Backpressure: none; the result feeds the stall decision directly.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] IdRs,
    input  logic [4:0] IdRt,
    input  logic       IdRtUsed,
    input  logic       ExMemRead,
    input  logic [4:0] ExRt,
    output logic       LuHazard
);

    logic rs_match;
    logic rt_match;

    // Register 0 is hardwired zero, so a load targeting it never creates a dependency
    assign rs_match = (ExRt == IdRs);
    assign rt_match = IdRtUsed && (ExRt == IdRt);
    assign LuHazard = ExMemRead && (ExRt != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: buffer enables, bubbles, PC write, perf counters.
// Latency: control outputs are Mealy (same cycle); state and counters update on clk.
// Backpressure: a not-ready data memory freezes Buf1-3 and the PC; timeout halts everything.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IdRs,
    input  logic [4:0]       IdRt,
    input  logic             IdRtUsed,
    input  logic             ExMemRead,
    input  logic [4:0]       ExRt,
    input  logic             MemBrTaken,
    input  logic             MemReq,
    input  logic             MemReady,
    output logic             PcWrite,
    output logic             Buf1En,
    output logic             Buf2En,
    output logic             Buf3En,
    output logic             Buf4En,
    output logic             Buf1Flush,
    output logic             Buf2Flush,
    output logic             Buf3Flush,
    output logic             Buf4Flush,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount,
    output logic             MemErr
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_t              state;
    state_t              state_nxt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [WAIT_W-1:0]   wait_nxt;
    logic [NUM_BUFS-1:0] buf_en;
    logic [NUM_BUFS-1:0] buf_flush;
    logic                pc_write;
    logic                stall_inc;
    logic                flush_inc;
    logic                err_set;
    logic                use_r1;
    logic                use_r2;
    logic                use_r3;
    logic                frozen;
    logic                lu_hazard;

    hazard_detect u_hazard_detect (
        .IdRs      (IdRs),
        .IdRt      (IdRt),
        .IdRtUsed  (IdRtUsed),
        .ExMemRead (ExMemRead),
        .ExRt      (ExRt),
        .LuHazard  (lu_hazard)
    );

    // Next-state, wait counter and Mealy control outputs from state and hazard inputs
    always_comb begin
        buf_en    = '1;
        buf_flush = '0;
        pc_write  = 1'b1;
        state_nxt = state;
        wait_nxt  = wait_cnt;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        err_set   = 1'b0;
        use_r1    = 1'b0;
        use_r2    = 1'b0;
        use_r3    = 1'b0;
        frozen    = 1'b0;

        case (state)
            RUN: begin
                // Memory wait outranks a branch even though both should never coincide
                if (MemReq && !MemReady) begin
                    use_r1    = 1'b1;
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else if (MemBrTaken) begin
                    use_r2 = 1'b1;
                end else if (lu_hazard) begin
                    use_r3 = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!MemReady) begin
                    use_r1 = 1'b1;
                    if (wait_cnt == WAIT_LIMIT) begin
                        state_nxt = HALT;
                        err_set   = 1'b1;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    // Release cycle: the access retires, so only branch/load-use apply
                    state_nxt = RUN;
                    wait_nxt  = '0;
                    if (MemBrTaken) begin
                        use_r2 = 1'b1;
                    end else if (lu_hazard) begin
                        use_r3 = 1'b1;
                    end
                end
            end
            HALT: begin
                frozen = 1'b1;
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase

        if (frozen) begin
            buf_en   = '0;
            pc_write = 1'b0;
        end else if (use_r1) begin
            // Hold IF..EX in place; MEM/WB takes a bubble so WB sees nothing twice
            pc_write        = 1'b0;
            buf_en          = '0;
            buf_en[BUF4]    = 1'b1;
            buf_flush[BUF4] = 1'b1;
            stall_inc       = 1'b1;
        end else if (use_r2) begin
            // Squash the three younger instructions; PC mux picks the target externally
            buf_flush[BUF1] = 1'b1;
            buf_flush[BUF2] = 1'b1;
            buf_flush[BUF3] = 1'b1;
            flush_inc       = 1'b1;
        end else if (use_r3) begin
            // Keep the dependent instruction in ID one cycle, bubble into EX
            pc_write        = 1'b0;
            buf_en[BUF1]    = 1'b0;
            buf_flush[BUF2] = 1'b1;
            stall_inc       = 1'b1;
        end

        // During reset every buffer loads a bubble and the PC holds
        if (rst) begin
            buf_en    = '1;
            buf_flush = '1;
            pc_write  = 1'b0;
        end
    end

    assign PcWrite   = pc_write;
    assign Buf1En    = buf_en[BUF1];
    assign Buf2En    = buf_en[BUF2];
    assign Buf3En    = buf_en[BUF3];
    assign Buf4En    = buf_en[BUF4];
    assign Buf1Flush = buf_flush[BUF1];
    assign Buf2Flush = buf_flush[BUF2];
    assign Buf3Flush = buf_flush[BUF3];
    assign Buf4Flush = buf_flush[BUF4];

    // State register, wait counter, sticky error flag and saturating perf counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            StallCycles <= '0;
            FlushCount  <= '0;
            MemErr      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (err_set) begin
                MemErr <= 1'b1;
            end
            if (stall_inc && (StallCycles != '1)) begin
                StallCycles <= StallCycles + CNT_W'(1);
            end
            if (flush_inc && (FlushCount != '1)) begin
                FlushCount <= FlushCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  IdRs = '0;
    logic [4:0]  IdRt = '0;
    logic        IdRtUsed = 1'b0;
    logic        ExMemRead = 1'b0;
    logic [4:0]  ExRt = '0;
    logic        MemBrTaken = 1'b0;
    logic        MemReq = 1'b0;
    logic        MemReady = 1'b0;
    logic        PcWrite;
    logic        Buf1En, Buf2En, Buf3En, Buf4En;
    logic        Buf1Flush, Buf2Flush, Buf3Flush, Buf4Flush;
    logic [15:0] StallCycles;
    logic [15:0] FlushCount;
    logic        MemErr;

    // {PcWrite, Buf1En..Buf4En, Buf1Flush..Buf4Flush}
    localparam logic [8:0] C_DEF  = 9'b1_1111_0000;
    localparam logic [8:0] C_R1   = 9'b0_0001_0001;
    localparam logic [8:0] C_R2   = 9'b1_1111_1110;
    localparam logic [8:0] C_R3   = 9'b0_0111_0100;
    localparam logic [8:0] C_HALT = 9'b0_0000_0000;
    localparam logic [8:0] C_RST  = 9'b0_1111_1111;

    typedef struct {
        int          id;
        logic [8:0]  ctrl;
        logic [15:0] st;
        logic [15:0] fl;
        logic        me;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   step_id = 0;
    logic [8:0] act_ctrl;

    assign act_ctrl = {PcWrite, Buf1En, Buf2En, Buf3En, Buf4En,
                       Buf1Flush, Buf2Flush, Buf3Flush, Buf4Flush};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .IdRs(IdRs), .IdRt(IdRt), .IdRtUsed(IdRtUsed),
        .ExMemRead(ExMemRead), .ExRt(ExRt),
        .MemBrTaken(MemBrTaken), .MemReq(MemReq), .MemReady(MemReady),
        .PcWrite(PcWrite),
        .Buf1En(Buf1En), .Buf2En(Buf2En), .Buf3En(Buf3En), .Buf4En(Buf4En),
        .Buf1Flush(Buf1Flush), .Buf2Flush(Buf2Flush), .Buf3Flush(Buf3Flush), .Buf4Flush(Buf4Flush),
        .StallCycles(StallCycles), .FlushCount(FlushCount), .MemErr(MemErr)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic rtu, input logic lr, input logic [4:0] ert,
                         input logic br, input logic mq, input logic mr);
        @(posedge clk);
        #1;
        rst = r; IdRs = rs; IdRt = rt; IdRtUsed = rtu;
        ExMemRead = lr; ExRt = ert; MemBrTaken = br; MemReq = mq; MemReady = mr;
    endtask

    task automatic expect_cyc(input logic [8:0] c, input logic [15:0] st,
                              input logic [15:0] fl, input logic me);
        exp_t e;
        e.id = step_id; e.ctrl = c; e.st = st; e.fl = fl; e.me = me;
        q.push_back(e);
        step_id++;
    endtask

    // Monitor: compare every cycle that has a queued expectation, mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                tests += 4;
                if (act_ctrl !== e.ctrl) begin
                    fails++;
                    $display("FAIL ctrl step %0d: got %b want %b", e.id, act_ctrl, e.ctrl);
                end
                if (StallCycles !== e.st) begin
                    fails++;
                    $display("FAIL stall_cnt step %0d: got %h want %h", e.id, StallCycles, e.st);
                end
                if (FlushCount !== e.fl) begin
                    fails++;
                    $display("FAIL flush_cnt step %0d: got %h want %h", e.id, FlushCount, e.fl);
                end
                if (MemErr !== e.me) begin
                    fails++;
                    $display("FAIL mem_err step %0d: got %b want %b", e.id, MemErr, e.me);
                end
            end
        end
    end

    initial begin
        // Reset: bubbles everywhere, PC held, counters cleared
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0); expect_cyc(C_RST, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0); expect_cyc(C_RST, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cyc(C_DEF, 0, 0, 0);

        // Load-use on rs: one bubble, then defaults
        apply(0, 5, 0, 0, 1, 5, 0, 0, 0); expect_cyc(C_R3, 0, 0, 0);
        apply(0, 5, 0, 0, 0, 5, 0, 0, 0); expect_cyc(C_DEF, 1, 0, 0);
        // Load to r0 never stalls
        apply(0, 0, 0, 0, 1, 0, 0, 0, 0); expect_cyc(C_DEF, 1, 0, 0);
        // rt matches but is not a source
        apply(0, 3, 7, 0, 1, 7, 0, 0, 0); expect_cyc(C_DEF, 1, 0, 0);
        // rt matches and is a source
        apply(0, 3, 7, 1, 1, 7, 0, 0, 0); expect_cyc(C_R3, 1, 0, 0);
        apply(0, 3, 7, 1, 0, 7, 0, 0, 0); expect_cyc(C_DEF, 2, 0, 0);

        // Taken branch
        apply(0, 0, 0, 0, 0, 0, 1, 0, 0); expect_cyc(C_R2, 2, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cyc(C_DEF, 2, 1, 0);

        // Three-cycle memory wait, release not counted
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_cyc(C_R1, 2, 1, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_cyc(C_R1, 3, 1, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_cyc(C_R1, 4, 1, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1); expect_cyc(C_DEF, 5, 1, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cyc(C_DEF, 5, 1, 0);

        // Memory wait and branch together: wait wins; branch acted on at release
        apply(0, 0, 0, 0, 0, 0, 1, 1, 0); expect_cyc(C_R1, 5, 1, 0);
        apply(0, 0, 0, 0, 0, 0, 1, 0, 1); expect_cyc(C_R2, 6, 1, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cyc(C_DEF, 6, 2, 0);

        // Timeout: five not-ready cycles, then HALT
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_cyc(C_R1, 6, 2, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_cyc(C_R1, 7, 2, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_cyc(C_R1, 8, 2, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_cyc(C_R1, 9, 2, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_cyc(C_R1, 10, 2, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1); expect_cyc(C_HALT, 11, 2, 1);
        apply(0, 5, 0, 0, 1, 5, 1, 0, 1); expect_cyc(C_HALT, 11, 2, 1);
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0); expect_cyc(C_RST, 11, 2, 1);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cyc(C_DEF, 0, 0, 0);

        // Drive the stall counter to all-ones with a held load-use hazard
        for (int i = 0; i < 65535; i++) begin
            apply(0, 5, 0, 0, 1, 5, 0, 0, 0);
        end
        apply(0, 5, 0, 0, 1, 5, 0, 0, 0); expect_cyc(C_R3, 16'hFFFF, 0, 0);
        apply(0, 5, 0, 0, 1, 5, 0, 0, 0); expect_cyc(C_R3, 16'hFFFF, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cyc(C_DEF, 16'hFFFF, 0, 0);

        // Reset mid-wait returns to RUN (no freeze afterwards despite MemReady=0)
        apply(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_cyc(C_R1, 16'hFFFF, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0, 1, 0); expect_cyc(C_RST, 16'hFFFF, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_cyc(C_DEF, 0, 0, 0);

        @(negedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
